infix_tokenizer_tx: RTL

- Shunting-yard converter that takes an infix token stream and transmits it, in postfix order, to the postfix calculator's token input.
- It is the transmitter side of the calculator's strobe/ack token interface.
- Supports operator precedence, right-associative EXP, and parentheses.
- Holds pending operators in an internal operator stack.

---
 rtl/infix_tokenizer_tx_if.sv | 13 +
 rtl/infix_tokenizer_tx.sv | 110 +++++++++++
 2 files changed

// File: rtl/infix_tokenizer_tx_if.sv
// infix_tokenizer_tx_if: infix in_* strobe/ack token input, postfix out_* strobe/ack token output, err/busy status; master = tokenizer, slave = its environment
interface infix_tokenizer_tx_if #(parameter int DATA_W = 32);
  logic in_stb, in_ack, in_is_operator, out_stb, out_ack, out_is_operator, err, busy;
  logic [DATA_W-1:0] in_data, out_data;
  modport master (
    input in_stb, in_data, in_is_operator, out_ack,
    output in_ack, out_stb, out_data, out_is_operator, err, busy
  );
  modport slave (
    output in_stb, in_data, in_is_operator, out_ack,
    input in_ack, out_stb, out_data, out_is_operator, err, busy
  );
endinterface

// File: rtl/infix_tokenizer_tx.sv
// infix_tokenizer_tx: shunting-yard infix-to-postfix token transmitter; ports CLK, RST (sync active-low), bus (master: infix tokens in, postfix tokens out, sticky err, busy)
module infix_tokenizer_tx #(
  parameter int OP_DEPTH = 16,
  parameter int DATA_W = 32
) (
  input logic CLK,
  input logic RST,
  infix_tokenizer_tx_if.master bus
);
  localparam int AW = $clog2(OP_DEPTH);
  typedef enum logic [2:0] {IDLE, DISPATCH, REDUCE, EMIT, GAP, PUSH, ACK} state_t;
  state_t state, ret;
  logic [DATA_W-1:0] tok;
  logic tok_op;
  logic [2:0] stk [OP_DEPTH];
  logic [AW:0] sp;
  logic [2:0] op, top;
  logic empty, full, pop;
  function automatic logic [1:0] prec(input logic [2:0] o);
    return o[2] ? 2'd3 : o[1] ? 2'd2 : 2'd1;
  endfunction
  always_comb begin
    op = tok[2:0];
    top = stk[AW'(sp - 1'b1)];
    empty = sp == '0;
    full = sp == (AW+1)'(OP_DEPTH);
    pop = !empty && top != 3'd6 &&
          (op > 3'd4 || prec(top) > prec(op) || (prec(top) == prec(op) && op != 3'd4));
  end
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= IDLE;
      ret <= IDLE;
      sp <= '0;
      tok <= '0;
      tok_op <= 1'b0;
      bus.in_ack <= 1'b0;
      bus.out_stb <= 1'b0;
      bus.out_data <= '0;
      bus.out_is_operator <= 1'b0;
      bus.err <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_stb) begin
          tok <= bus.in_data;
          tok_op <= bus.in_is_operator;
          bus.busy <= 1'b1;
          state <= DISPATCH;
        end
        DISPATCH: if (!tok_op) begin
          bus.out_data <= tok;
          bus.out_is_operator <= 1'b0;
          bus.out_stb <= 1'b1;
          ret <= ACK;
          state <= EMIT;
        end else state <= op == 3'd6 ? PUSH : REDUCE;
        REDUCE: if (pop) begin
          sp <= sp - 1'b1;
          bus.out_data <= DATA_W'(top);
          bus.out_is_operator <= 1'b1;
          bus.out_stb <= 1'b1;
          ret <= REDUCE;
          state <= EMIT;
        end else if (op == 3'd7) begin
          // a non-empty stack here has '(' on top: consume it silently
          bus.err <= bus.err | empty;
          if (!empty) sp <= sp - 1'b1;
          bus.in_ack <= 1'b1;
          state <= ACK;
        end else if (op == 3'd5) begin
          if (empty) begin
            bus.out_data <= DATA_W'(op);
            bus.out_is_operator <= 1'b1;
            bus.out_stb <= 1'b1;
            ret <= ACK;
            state <= EMIT;
          end else begin
            // unmatched '(' met while flushing
            bus.err <= 1'b1;
            sp <= sp - 1'b1;
          end
        end else state <= PUSH;
        EMIT: if (bus.out_ack) begin
          bus.out_stb <= 1'b0;
          state <= GAP;
        end
        GAP: begin
          bus.in_ack <= ret == ACK;
          state <= ret;
        end
        PUSH: begin
          if (full) bus.err <= 1'b1;
          else begin
            stk[sp[AW-1:0]] <= op;
            sp <= sp + 1'b1;
          end
          bus.in_ack <= 1'b1;
          state <= ACK;
        end
        ACK: begin
          bus.in_ack <= 1'b0;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
